tsic_serial_comm: RTL

// - Host-facing end of the TSIC command/response link: 8N1 UART, full duplex.
// - RX: assembles two bytes into a 16-bit command and hands it to TSIC_cntrl (cmd_rdy/cmd).
// - TX: on TSIC_cntrl's trmt, sends the 16-bit result back as two bytes, high byte first.
// - Sits between the board RX/TX pins and TSIC_cntrl plus its datapath.

---
 rtl/tsic_comm_pkg.sv | 14 +
 rtl/tsic_uart_tx8.sv | 75 +++++++
 rtl/tsic_serial_comm.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tsic_comm_pkg.sv
// Shared types and constants for the TSIC host serial link.
//   rx_state_t / tx_state_t : receive / transmit bit-level FSM states
//   FRAME_BITS              : start + 8 data + stop
//   CMD_*                   : opcodes carried in cmd[15:14]
package tsic_comm_pkg;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    localparam int FRAME_BITS = 10;

    localparam logic [1:0] CMD_WR_OFF  = 2'b00;
    localparam logic [1:0] CMD_WR_GAIN = 2'b01;
    localparam logic [1:0] CMD_RD_TEMP = 2'b10;
endpackage

// File: rtl/tsic_uart_tx8.sv
// 8N1 byte serializer, LSB first, each bit exactly BAUD_DIV clocks.
//   clk, rst : clock, async active-high reset
//   load     : take data; honoured when idle or in the last stop-bit cycle
//   data     : byte to send
//   tx       : serial out, idles high
//   busy     : frame in progress
//   done     : 1-clk pulse in the last cycle of the stop bit
module tsic_uart_tx8
    import tsic_comm_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam logic [11:0] BIT_LAST = 12'(BAUD_DIV - 1);

    tx_state_t   state, state_n;
    logic [11:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        bit_end, take;

    assign bit_end = (cnt == BIT_LAST);
    assign done    = (state == TX_STOP) && bit_end;
    // Loading on the final stop cycle chains the next byte with no gap.
    assign take    = load && (state == TX_IDLE || done);
    assign busy    = (state != TX_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= TX_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        tx      = 1'b1;
        case (state)
            TX_IDLE:  if (take) state_n = TX_START;
            TX_START: begin
                tx = 1'b0;
                if (bit_end) state_n = TX_DATA;
            end
            TX_DATA: begin
                tx = shreg[0];
                if (bit_end && bit_idx == 3'd7) state_n = TX_STOP;
            end
            TX_STOP:  if (bit_end) state_n = take ? TX_START : TX_IDLE;
            default:  state_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            // Reload on every bit boundary so no error accumulates.
            if (state == TX_IDLE || state_n != state || bit_end) cnt <= '0;
            else                                                 cnt <= cnt + 12'd1;

            if (state == TX_START)                bit_idx <= '0;
            else if (state == TX_DATA && bit_end) bit_idx <= bit_idx + 3'd1;

            if (take)                             shreg <= data;
            else if (state == TX_DATA && bit_end) shreg <= {1'b0, shreg[7:1]};
        end
    end
endmodule

// File: rtl/tsic_serial_comm.sv
// Host-facing TSIC link: 8N1 UART, full duplex.
//   clk, rst      : clock, async active-high reset
//   RX            : serial in (async), two bytes form one command, high byte first
//   cmd, cmd_rdy  : last complete command and its 1-clk valid pulse
//   frm_err       : 1-clk pulse on bad stop bit or inter-byte timeout
//   trmt, resp    : start sending resp (high byte first), accepted only when idle
//   TX            : serial out
//   tx_busy       : transmit in progress (low again in the tx_done cycle)
//   tx_done       : 1-clk pulse at the end of the second stop bit
module tsic_serial_comm
    import tsic_comm_pkg::*;
#(
    parameter int BAUD_DIV = 434,
    parameter int BYTE_TO  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        frm_err,
    input  logic        trmt,
    input  logic [15:0] resp,
    output logic        tx_busy,
    output logic        tx_done
);
    localparam logic [11:0] BIT_LAST = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF     = 12'(BAUD_DIV / 2);
    localparam int          TO_CLKS  = BYTE_TO * BAUD_DIV;
    localparam int          TO_W     = $clog2(TO_CLKS);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CLKS - 1);

    // ---------------- TX: two bytes back to back ----------------
    logic       accept, ser_load, ser_busy, ser_done, tx_idx;
    logic [7:0] resp_lo, ser_data;

    assign accept   = trmt && !ser_busy;
    assign ser_load = accept || (ser_done && !tx_idx);
    assign ser_data = accept ? resp[15:8] : resp_lo;
    assign tx_done  = ser_done && tx_idx;
    assign tx_busy  = ser_busy && !tx_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_idx  <= 1'b0;
            resp_lo <= '0;
        end else if (accept) begin
            tx_idx  <= 1'b0;
            resp_lo <= resp[7:0];
        end else if (ser_done) begin
            tx_idx  <= !tx_idx;
        end
    end

    tsic_uart_tx8 #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk  (clk),
        .rst  (rst),
        .load (ser_load),
        .data (ser_data),
        .tx   (TX),
        .busy (ser_busy),
        .done (ser_done)
    );

    // ---------------- RX ----------------
    logic            rx_s1, rx_s2, rx_prev, fall;
    rx_state_t       rx_state, rx_state_n;
    logic [11:0]     rx_cnt;
    logic [2:0]      rx_bits;
    logic [7:0]      rx_sh, rx_hi;
    logic            rx_idx, bit_end, stop_smp;
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) {rx_s1, rx_s2, rx_prev} <= 3'b111;
        else     {rx_s1, rx_s2, rx_prev} <= {RX, rx_s1, rx_s2};
    end

    assign fall     = rx_prev && !rx_s2;
    assign bit_end  = (rx_cnt == BIT_LAST);
    assign stop_smp = (rx_state == RX_STOP) && bit_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_state_n;
    end

    always_comb begin
        rx_state_n = rx_state;
        case (rx_state)
            RX_IDLE:  if (fall) rx_state_n = RX_START;
            // Mid start bit: a high line means it was a glitch.
            RX_START: if (rx_cnt == HALF) rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_end && rx_bits == 3'd7) rx_state_n = RX_STOP;
            RX_STOP:  if (bit_end) rx_state_n = RX_IDLE;
            default:  rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt  <= '0;
            rx_bits <= '0;
            rx_sh   <= '0;
        end else begin
            if (rx_state == RX_IDLE || rx_state_n != rx_state || bit_end) rx_cnt <= '0;
            else                                                         rx_cnt <= rx_cnt + 12'd1;

            if (rx_state == RX_START)                rx_bits <= '0;
            else if (rx_state == RX_DATA && bit_end) rx_bits <= rx_bits + 3'd1;

            if (rx_state == RX_DATA && bit_end) rx_sh <= {rx_s2, rx_sh[7:1]};
        end
    end

    // Byte pairing, command hand-off and inter-byte timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_idx  <= 1'b0;
            rx_hi   <= '0;
            to_cnt  <= '0;
            cmd     <= '0;
            cmd_rdy <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            cmd_rdy <= 1'b0;
            frm_err <= 1'b0;
            if (stop_smp) begin
                if (!rx_s2) begin
                    frm_err <= 1'b1;
                    rx_idx  <= 1'b0;
                end else if (!rx_idx) begin
                    rx_hi  <= rx_sh;
                    rx_idx <= 1'b1;
                    to_cnt <= '0;
                end else begin
                    cmd     <= {rx_hi, rx_sh};
                    cmd_rdy <= 1'b1;
                    rx_idx  <= 1'b0;
                end
            end else if (rx_idx && rx_state == RX_IDLE) begin
                // Only idle line time counts toward the timeout.
                if (to_cnt == TO_LAST) begin
                    frm_err <= 1'b1;
                    rx_idx  <= 1'b0;
                    rx_hi   <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end
endmodule
